// File: rtl/mult_const_lift_seq.sv
// Batch constant-multiply stage: issues N share reads, multiplies each share by a
// per-index constant from a writable two-table RAM, and tags products with valid/idx/last.
module mult_const_lift_seq #(
    parameter int W       = 30,
    parameter int N       = 7,
    parameter int AW      = 3,
    parameter int MUL_LAT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             tab_sel,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_en,
    input  logic [W-1:0]     ap_shares,
    input  logic             cfg_we,
    input  logic             cfg_tab,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [W-1:0]     cfg_data,
    output logic             busy,
    output logic [2*W-1:0]   out,
    output logic             out_valid,
    output logic [AW-1:0]    out_idx,
    output logic             out_last,
    output logic             done
);

    localparam int            DEPTH     = 2**AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N-1);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    genvar gi;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          tab_q, tab_d;
    logic          issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tab_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tab_q   <= tab_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tab_d   = tab_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                    tab_d   = tab_sel;
                end
            end
            ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign issue   = (state_q == ISSUE);
    assign rd_en   = issue;
    assign busy    = issue;
    assign rd_addr = addr_q;

    // Constant tables keep their contents across reset; only power-up loads defaults.
    logic [W-1:0] tab0_mem [DEPTH] = '{
        0: W'(64'd318931683), 1: W'(64'd991350525), 2: W'(64'd428501086),
        3: W'(64'd665588608), 4: W'(64'd602266786), 5: W'(64'd734861690),
        6: W'(64'd373752559), default: '0
    };
    logic [W-1:0] tab1_mem [DEPTH] = '{default: '0};

    logic         wr_ok;
    logic [W-1:0] rd0_q, rd1_q;
    logic         sel_q;

    assign wr_ok = ({1'b0, cfg_addr} < (AW+1)'(N));

    // Read-before-write: a same-cycle write to the addressed entry returns the old value.
    always_ff @(posedge clk) begin
        if (cfg_we && wr_ok && !cfg_tab) begin
            tab0_mem[cfg_addr] <= cfg_data;
        end
        rd0_q <= tab0_mem[addr_q];
    end

    always_ff @(posedge clk) begin
        if (cfg_we && wr_ok && cfg_tab) begin
            tab1_mem[cfg_addr] <= cfg_data;
        end
        rd1_q <= tab1_mem[addr_q];
    end

    always_ff @(posedge clk) begin
        sel_q <= tab_q;
    end

    logic [W-1:0]   opa_q, opb_q;
    logic [2*W-1:0] mul_w, prod_tail;

    always_ff @(posedge clk) begin
        opa_q <= ap_shares;
        opb_q <= sel_q ? rd1_q : rd0_q;
    end

    assign mul_w = (2*W)'(opa_q) * (2*W)'(opb_q);

    // Operand register counts as the first of the MUL_LAT multiplier stages.
    generate
        if (MUL_LAT == 1) begin : g_no_pipe
            assign prod_tail = mul_w;
        end else begin : g_pipe
            logic [2*W-1:0] stage_q [MUL_LAT-1];
            for (gi = 0; gi < MUL_LAT-1; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    always_ff @(posedge clk) stage_q[gi] <= mul_w;
                end else begin : g_next
                    always_ff @(posedge clk) stage_q[gi] <= stage_q[gi-1];
                end
            end
            assign prod_tail = stage_q[MUL_LAT-2];
        end
    endgenerate

    // Tag line: one stage per cycle from the issue cycle up to the output register.
    logic          tvld_q  [MUL_LAT+1];
    logic          tlast_q [MUL_LAT+1];
    logic [AW-1:0] tidx_q  [MUL_LAT+1];

    generate
        for (gi = 0; gi <= MUL_LAT; gi++) begin : g_tag
            logic          vld_src, last_src;
            logic [AW-1:0] idx_src;
            if (gi == 0) begin : g_head
                assign vld_src  = issue;
                assign last_src = issue && (addr_q == LAST_ADDR);
                assign idx_src  = addr_q;
            end else begin : g_body
                assign vld_src  = tvld_q[gi-1];
                assign last_src = tlast_q[gi-1];
                assign idx_src  = tidx_q[gi-1];
            end
            always_ff @(posedge clk) begin
                if (rst) begin
                    tvld_q[gi]  <= 1'b0;
                    tlast_q[gi] <= 1'b0;
                    tidx_q[gi]  <= '0;
                end else begin
                    tvld_q[gi]  <= vld_src;
                    tlast_q[gi] <= last_src;
                    tidx_q[gi]  <= idx_src;
                end
            end
        end
    endgenerate

    logic [2*W-1:0] out_q;
    logic           out_valid_q, out_last_q, done_q;
    logic [AW-1:0]  out_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= tvld_q[MUL_LAT];
            out_q       <= tvld_q[MUL_LAT] ? prod_tail : '0;
            out_idx_q   <= tvld_q[MUL_LAT] ? tidx_q[MUL_LAT] : '0;
            out_last_q  <= tvld_q[MUL_LAT] & tlast_q[MUL_LAT];
            done_q      <= tvld_q[MUL_LAT] & tlast_q[MUL_LAT];
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule
